// File: rtl/otter_pipe_pkg.sv
// Shared types for the Otter pipeline stage registers.
// Control word layout and the all-zero bubble constant.
package otter_pipe_pkg;

  typedef enum logic [2:0] {
    NO_BRANCH = 3'd0,
    BEQ       = 3'd1,
    BNE       = 3'd2,
    BLT       = 3'd3,
    BGE       = 3'd4,
    BLTU      = 3'd5,
    BGEU      = 3'd6
  } branch_t;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic       srca_sel;
    logic [1:0] srcb_sel;
    logic [1:0] rf_sel;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read2;
    branch_t    br_type;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register.
// master = decoder/front end, slave = the pipeline register.
interface id_ex_pipe_reg_if #(
  parameter int XLEN = 32
);
  logic            ID_VALID;
  logic [XLEN-1:0] ID_PC;
  logic [4:0]      ID_RS1_ADDR;
  logic [4:0]      ID_RS2_ADDR;
  logic [4:0]      ID_RD_ADDR;
  logic [XLEN-1:0] ID_RS1_DATA;
  logic [XLEN-1:0] ID_RS2_DATA;
  logic [XLEN-1:0] ID_IMM;
  logic [3:0]      ID_ALU_FUN;
  logic            ID_SRCA_SEL;
  logic [1:0]      ID_SRCB_SEL;
  logic [1:0]      ID_RF_SEL;
  logic            ID_REG_WRITE;
  logic            ID_MEM_WRITE;
  logic            ID_MEM_READ2;
  logic [2:0]      ID_BR_TYPE;

  logic            EX_VALID;
  logic [XLEN-1:0] EX_PC;
  logic [4:0]      EX_RS1_ADDR;
  logic [4:0]      EX_RS2_ADDR;
  logic [4:0]      EX_RD_ADDR;
  logic [XLEN-1:0] EX_RS1_DATA;
  logic [XLEN-1:0] EX_RS2_DATA;
  logic [XLEN-1:0] EX_IMM;
  logic [3:0]      EX_ALU_FUN;
  logic            EX_SRCA_SEL;
  logic [1:0]      EX_SRCB_SEL;
  logic [1:0]      EX_RF_SEL;
  logic            EX_REG_WRITE;
  logic            EX_MEM_WRITE;
  logic            EX_MEM_READ2;
  logic [2:0]      EX_BR_TYPE;

  modport master (
    output ID_VALID, ID_PC,
    output ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR,
    output ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
    output ID_ALU_FUN, ID_SRCA_SEL, ID_SRCB_SEL,
    output ID_RF_SEL, ID_REG_WRITE, ID_MEM_WRITE,
    output ID_MEM_READ2, ID_BR_TYPE,
    input  EX_VALID, EX_PC,
    input  EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR,
    input  EX_RS1_DATA, EX_RS2_DATA, EX_IMM,
    input  EX_ALU_FUN, EX_SRCA_SEL, EX_SRCB_SEL,
    input  EX_RF_SEL, EX_REG_WRITE, EX_MEM_WRITE,
    input  EX_MEM_READ2, EX_BR_TYPE
  );

  modport slave (
    input  ID_VALID, ID_PC,
    input  ID_RS1_ADDR, ID_RS2_ADDR, ID_RD_ADDR,
    input  ID_RS1_DATA, ID_RS2_DATA, ID_IMM,
    input  ID_ALU_FUN, ID_SRCA_SEL, ID_SRCB_SEL,
    input  ID_RF_SEL, ID_REG_WRITE, ID_MEM_WRITE,
    input  ID_MEM_READ2, ID_BR_TYPE,
    output EX_VALID, EX_PC,
    output EX_RS1_ADDR, EX_RS2_ADDR, EX_RD_ADDR,
    output EX_RS1_DATA, EX_RS2_DATA, EX_IMM,
    output EX_ALU_FUN, EX_SRCA_SEL, EX_SRCB_SEL,
    output EX_RF_SEL, EX_REG_WRITE, EX_MEM_WRITE,
    output EX_MEM_READ2, EX_BR_TYPE
  );
endinterface

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// Load-use hazard: a valid load in EX writes a register ID reads.
// rs2 is always compared, even for instructions that ignore it.
module hazard_detect (
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read2_i,
  input  logic [4:0] ex_rd_addr_i,
  output logic       hazard_o
);

  logic rd_nz;
  logic match;

  assign rd_nz = |ex_rd_addr_i;
  assign match = (ex_rd_addr_i == id_rs1_addr_i) |
                 (ex_rd_addr_i == id_rs2_addr_i);

  assign hazard_o = ex_valid_i & ex_mem_read2_i &
                    rd_nz & match;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion.
// OTTER_PERF_CNT_EN adds stall and flush cycle counters.
module id_ex_pipe_reg
  import otter_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic CLK,
  input  logic RST_N,
  id_ex_pipe_reg_if.slave bus,
  input  logic EX_HOLD,
  input  logic EX_FLUSH,
  output logic STALL_IFID
`ifdef OTTER_PERF_CNT_EN
  ,
  output logic [31:0] STALL_CNT,
  output logic [31:0] FLUSH_CNT
`endif
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    id_ex_ctrl_t     ctrl;
  } ex_t;

  localparam ex_t EX_BUBBLE = '0;

  ex_t  id_w;
  ex_t  ex_d;
  ex_t  ex_q;
  logic hz_raw;
  logic hazard;
  logic do_flush;
  logic do_hold;
  logic do_bub;

  always_comb begin
    id_w = EX_BUBBLE;
    id_w.valid          = 1'b1;
    id_w.pc             = bus.ID_PC;
    id_w.rs1_addr       = bus.ID_RS1_ADDR;
    id_w.rs2_addr       = bus.ID_RS2_ADDR;
    id_w.rd_addr        = bus.ID_RD_ADDR;
    id_w.rs1_data       = bus.ID_RS1_DATA;
    id_w.rs2_data       = bus.ID_RS2_DATA;
    id_w.imm            = bus.ID_IMM;
    id_w.ctrl.alu_fun   = bus.ID_ALU_FUN;
    id_w.ctrl.srca_sel  = bus.ID_SRCA_SEL;
    id_w.ctrl.srcb_sel  = bus.ID_SRCB_SEL;
    id_w.ctrl.rf_sel    = bus.ID_RF_SEL;
    id_w.ctrl.reg_write = bus.ID_REG_WRITE;
    id_w.ctrl.mem_write = bus.ID_MEM_WRITE;
    id_w.ctrl.mem_read2 = bus.ID_MEM_READ2;
    id_w.ctrl.br_type   = branch_t'(bus.ID_BR_TYPE);
  end

  hazard_detect u_hazard (
    .id_rs1_addr_i  (bus.ID_RS1_ADDR),
    .id_rs2_addr_i  (bus.ID_RS2_ADDR),
    .ex_valid_i     (ex_q.valid),
    .ex_mem_read2_i (ex_q.ctrl.mem_read2),
    .ex_rd_addr_i   (ex_q.rd_addr),
    .hazard_o       (hz_raw)
  );

  assign hazard = bus.ID_VALID & hz_raw;

  // priority flush > hold > hazard, made one-hot for the case
  assign do_flush = EX_FLUSH;
  assign do_hold  = EX_HOLD & ~EX_FLUSH;
  assign do_bub   = hazard & ~EX_FLUSH & ~EX_HOLD;

  assign STALL_IFID = do_hold | do_bub;

  always_comb begin
    ex_d = ex_q;
    unique case (1'b1)
      do_flush: ex_d = EX_BUBBLE;
      do_hold:  ex_d = ex_q;
      do_bub:   ex_d = EX_BUBBLE;
      default:  ex_d = bus.ID_VALID ? id_w : EX_BUBBLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ex_q <= EX_BUBBLE;
    else        ex_q <= ex_d;
  end

  assign bus.EX_VALID     = ex_q.valid;
  assign bus.EX_PC        = ex_q.pc;
  assign bus.EX_RS1_ADDR  = ex_q.rs1_addr;
  assign bus.EX_RS2_ADDR  = ex_q.rs2_addr;
  assign bus.EX_RD_ADDR   = ex_q.rd_addr;
  assign bus.EX_RS1_DATA  = ex_q.rs1_data;
  assign bus.EX_RS2_DATA  = ex_q.rs2_data;
  assign bus.EX_IMM       = ex_q.imm;
  assign bus.EX_ALU_FUN   = ex_q.ctrl.alu_fun;
  assign bus.EX_SRCA_SEL  = ex_q.ctrl.srca_sel;
  assign bus.EX_SRCB_SEL  = ex_q.ctrl.srcb_sel;
  assign bus.EX_RF_SEL    = ex_q.ctrl.rf_sel;
  assign bus.EX_REG_WRITE = ex_q.ctrl.reg_write;
  assign bus.EX_MEM_WRITE = ex_q.ctrl.mem_write;
  assign bus.EX_MEM_READ2 = ex_q.ctrl.mem_read2;
  assign bus.EX_BR_TYPE   = ex_q.ctrl.br_type;

`ifdef OTTER_PERF_CNT_EN
  logic [31:0] stall_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_d;
  logic [31:0] flush_cnt_q;

  assign stall_cnt_d = stall_cnt_q + {31'd0, STALL_IFID};
  assign flush_cnt_d = flush_cnt_q + {31'd0, EX_FLUSH};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule
